// File: rtl/bin_encoder_4to2.sv
// Registered 4-to-2 priority encoder with a valid/ready input, an acknowledged output
// and a saturating count of non-one-hot words.
module bin_encoder_4to2 #(
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i0,
    input  logic                 i1,
    input  logic                 i2,
    input  logic                 i3,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 y1,
    output logic                 y0,
    output logic                 any,
    output logic                 err,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    state_t               state_q, state_d;
    logic [1:0]           code_q, code_d;
    logic                 any_q, any_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]           word;
    logic                 accept;
    logic                 idleReady;

    assign word = {i3, i2, i1, i0};

    always_comb begin
        state_d   = state_q;
        idleReady = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                idleReady = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces in_ready low combinationally so nothing is offered during reset.
    assign in_ready = idleReady & ~rst;

    always_comb begin
        code_d = code_q;
        any_d  = any_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (accept) begin
            casez (word)
                4'b1???: code_d = 2'b11;
                4'b01??: code_d = 2'b10;
                4'b001?: code_d = 2'b01;
                default: code_d = 2'b00;
            endcase
            any_d = |word;
            // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
            err_d = (word == 4'd0) || ((word & (word - 4'd1)) != 4'd0);
            if (err_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
            any_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            any_q   <= any_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y1      = code_q[1];
    assign y0      = code_q[0];
    assign any     = any_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_bin_encoder_4to2.sv
// Self-checking bench for bin_encoder_4to2: directed scenarios plus random traffic,
// compared every cycle against a behavioural model for a 4-bit and a 2-bit counter instance.
module tb_bin_encoder_4to2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] word;
    logic       in_valid;
    logic       out_ack;

    logic       in_ready, y1, y0, any, err, out_valid;
    logic [3:0] err_cnt;
    logic       sIn_ready, sY1, sY0, sAny, sErr, sOut_valid;
    logic [1:0] sErr_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    bit mHold;
    int mY, mAny, mErr, mCnt, mCntSat;

    always #5 clk = ~clk;

    bin_encoder_4to2 #(.ERR_CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i0(word[0]), .i1(word[1]), .i2(word[2]), .i3(word[3]),
        .in_valid(in_valid), .in_ready(in_ready), .y1(y1), .y0(y0), .any(any), .err(err),
        .out_valid(out_valid), .out_ack(out_ack), .err_cnt(err_cnt)
    );

    bin_encoder_4to2 #(.ERR_CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .i0(word[0]), .i1(word[1]), .i2(word[2]), .i3(word[3]),
        .in_valid(in_valid), .in_ready(sIn_ready), .y1(sY1), .y0(sY0), .any(sAny), .err(sErr),
        .out_valid(sOut_valid), .out_ack(out_ack), .err_cnt(sErr_cnt)
    );

    // Behavioural model: result is the index of the highest set bit, error is popcount != 1.
    always @(posedge clk) begin
        if (rst) begin
            mHold = 1'b0; mY = 0; mAny = 0; mErr = 0; mCnt = 0; mCntSat = 0;
        end else if (!mHold) begin
            if (in_valid) begin
                mHold = 1'b1;
                mY    = 0;
                for (int k = 0; k < 4; k++) if (word[k]) mY = k;
                mAny  = (word != 4'd0) ? 1 : 0;
                mErr  = ($countones(word) != 1) ? 1 : 0;
                if (mErr == 1) begin
                    mCnt    = (mCnt + 1 > 15) ? 15 : mCnt + 1;
                    mCntSat = (mCntSat + 1 > 3) ? 3 : mCntSat + 1;
                end
            end
        end else if (out_ack) begin
            mHold = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready", int'(in_ready), (!mHold && !rst) ? 1 : 0);
            checkOutput("out_valid", int'(out_valid), mHold ? 1 : 0);
            checkOutput("y", int'({y1, y0}), mY);
            checkOutput("any", int'(any), mAny);
            checkOutput("err", int'(err), mErr);
            checkOutput("err_cnt", int'(err_cnt), mCnt);
            checkOutput("sat.in_ready", int'(sIn_ready), (!mHold && !rst) ? 1 : 0);
            checkOutput("sat.out_valid", int'(sOut_valid), mHold ? 1 : 0);
            checkOutput("sat.y", int'({sY1, sY0}), mY);
            checkOutput("sat.err", int'(sErr), mErr);
            checkOutput("sat.err_cnt", int'(sErr_cnt), mCntSat);
        end
    end

    task automatic applyStimulus(input logic [3:0] w, input logic v, input logic ack, input logic r);
        word     = w;
        in_valid = v;
        out_ack  = ack;
        rst      = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkHeld(input string name, input int expY, input int expAny,
                             input int expErr, input int expCnt);
        checkOutput({name, ".y"}, int'({y1, y0}), expY);
        checkOutput({name, ".any"}, int'(any), expAny);
        checkOutput({name, ".err"}, int'(err), expErr);
        checkOutput({name, ".err_cnt"}, int'(err_cnt), expCnt);
        checkOutput({name, ".out_valid"}, int'(out_valid), 1);
        checkOutput({name, ".in_ready"}, int'(in_ready), 0);
    endtask

    task automatic acceptAndHold(input logic [3:0] w);
        applyStimulus(w, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        settle();
    endtask

    task automatic ackOnce();
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] ill [3];
        int         illY [3];
        int         illAny [3];
        int         satExp [5];
        ill    = '{4'b0000, 4'b0110, 4'b1111};
        illY   = '{0, 2, 3};
        illAny = '{0, 1, 1};
        satExp = '{1, 2, 3, 3, 3};

        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkEn = 1'b1;
        settle();
        checkOutput("reset.out_valid", int'(out_valid), 0);
        checkOutput("reset.in_ready", int'(in_ready), 0);
        checkOutput("reset.y", int'({y1, y0, any, err}), 0);
        checkOutput("reset.err_cnt", int'(err_cnt), 0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("reset.in_ready_after", int'(in_ready), 1);

        for (int k = 0; k < 4; k++) begin
            acceptAndHold(4'b0001 << k);
            checkHeld($sformatf("onehot%0d", k), k, 1, 0, 0);
            ackOnce();
        end

        for (int ab = 0; ab < 4; ab++) begin
            logic [3:0] dec;
            dec = 4'b0001 << ab;
            acceptAndHold(dec);
            checkHeld($sformatf("roundtrip%0d", ab), ab, 1, 0, 0);
            ackOnce();
        end

        for (int k = 0; k < 3; k++) begin
            acceptAndHold(ill[k]);
            checkHeld($sformatf("illegal%0d", k), illY[k], illAny[k], 1, k + 1);
            ackOnce();
        end

        acceptAndHold(4'b0100);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'($urandom_range(15)), 1'b1, 1'b0, 1'b0);
            settle();
            checkHeld($sformatf("backpressure%0d", c), 2, 1, 0, 3);
            tick();
        end
        ackOnce();
        acceptAndHold(4'b0001);
        checkHeld("afterAck", 0, 1, 0, 3);
        ackOnce();

        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            acceptAndHold(4'b0000);
            checkOutput($sformatf("sat%0d.err_cnt", c), int'(sErr_cnt), satExp[c]);
            checkOutput($sformatf("wide%0d.err_cnt", c), int'(err_cnt), c + 1);
            ackOnce();
        end

        acceptAndHold(4'b1000);
        checkHeld("midHold", 3, 1, 0, 5);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("midHold.out_valid", int'(out_valid), 0);
        checkOutput("midHold.err_cnt", int'(err_cnt), 0);
        checkOutput("midHold.outputs", int'({y1, y0, any, err}), 0);
        checkOutput("midHold.in_ready", int'(in_ready), 1);

        for (int c = 0; c < 400; c++) begin
            applyStimulus(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          ($urandom_range(39) == 0));
            tick();
        end
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
